// File: rtl/mem_bridge_pkg.sv
// Shared definitions for the memory bridge: FSM encoding, requester ids and defaults.
package mem_bridge_pkg;

    localparam int DEFAULT_WORD_SIZE = 16;

    // Bridge FSM encoding
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    // Requester ids; also the bit positions inside the one-hot grant vector
    localparam logic PORT_I = 1'b0;
    localparam logic PORT_D = 1'b1;

    // Width of the latency down-counter: it only has to hold MEM_LATENCY-1
    function automatic int cnt_width(input int lat);
        return (lat > 1) ? $clog2(lat) : 1;
    endfunction

endpackage

// File: rtl/mem_rr_arb.sv
// Two-requester round-robin arbiter: a lone requester wins, a tie goes to the
// port that was not served last. Purely combinational.
module mem_rr_arb
    import mem_bridge_pkg::*;
(
    input  logic       i_req,
    input  logic       d_req,
    input  logic       last_grant,
    input  logic       enable,
    output logic [1:0] grant
);

    // One-hot grant, all zero when disabled or nobody asks
    always_comb begin
        grant = 2'b00;
        if (enable) begin
            if (i_req && d_req) begin
                if (last_grant == PORT_I) grant[PORT_D] = 1'b1;
                else                      grant[PORT_I] = 1'b1;
            end else if (i_req) begin
                grant[PORT_I] = 1'b1;
            end else if (d_req) begin
                grant[PORT_D] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_bridge.sv
// Memory bridge: serialises a fetch port and a data port onto one shared
// read/write memory bus, holding each access for MEM_LATENCY cycles.
module mem_bridge
    import mem_bridge_pkg::*;
#(
    parameter int WORD_SIZE   = DEFAULT_WORD_SIZE,
    parameter int MEM_LATENCY = 1
)
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 i_req,
    input  logic [WORD_SIZE-1:0] i_addr,
    output logic [WORD_SIZE-1:0] i_rdata,
    output logic                 i_done,
    input  logic                 d_req,
    input  logic                 d_we,
    input  logic [WORD_SIZE-1:0] d_addr,
    input  logic [WORD_SIZE-1:0] d_wdata,
    output logic [WORD_SIZE-1:0] d_rdata,
    output logic                 d_done,
    input  logic                 halt,
    output logic                 is_halted,
    output logic                 readM,
    output logic                 writeM,
    output logic [WORD_SIZE-1:0] address,
    inout  wire  [WORD_SIZE-1:0] data,
    output logic [WORD_SIZE-1:0] num_fetch
);

    localparam int CW = cnt_width(MEM_LATENCY);

    logic [1:0]           state;
    logic [CW-1:0]        lat_cnt;
    logic                 gnt_port;
    logic                 gnt_we;
    logic                 last_grant;
    logic [WORD_SIZE-1:0] wdata_hold;
    logic [1:0]           grant;

    // New grants only from IDLE and never while halted
    mem_rr_arb u_arb (
        .i_req      (i_req),
        .d_req      (d_req),
        .last_grant (last_grant),
        .enable     ((state == ST_IDLE) && !halt),
        .grant      (grant)
    );

    // Bus is driven only while a write strobe is out; writeM resets
    // asynchronously, so a reset releases the bus at once
    assign data = writeM ? wdata_hold : 'z;

    // Halt has taken effect once the bridge is idle
    assign is_halted = halt && (state == ST_IDLE);

    // Access sequencer: grant, hold strobe for the latency, then one response cycle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            lat_cnt    <= '0;
            gnt_port   <= PORT_I;
            gnt_we     <= 1'b0;
            last_grant <= PORT_I;
            wdata_hold <= '0;
            readM      <= 1'b0;
            writeM     <= 1'b0;
            address    <= '0;
            i_done     <= 1'b0;
            d_done     <= 1'b0;
            i_rdata    <= '0;
            d_rdata    <= '0;
            num_fetch  <= '0;
        end else begin
            i_done <= 1'b0;
            d_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (grant != 2'b00) begin
                        state   <= ST_BUSY;
                        lat_cnt <= CW'(MEM_LATENCY - 1);
                        if (grant[PORT_D]) begin
                            gnt_port   <= PORT_D;
                            gnt_we     <= d_we;
                            address    <= d_addr;
                            wdata_hold <= d_wdata;
                            readM      <= !d_we;
                            writeM     <= d_we;
                        end else begin
                            gnt_port <= PORT_I;
                            gnt_we   <= 1'b0;
                            address  <= i_addr;
                            readM    <= 1'b1;
                            writeM   <= 1'b0;
                        end
                    end
                end
                ST_BUSY: begin
                    if (lat_cnt == '0) begin
                        // Final bus cycle: capture read data and raise done for RESP
                        state      <= ST_RESP;
                        readM      <= 1'b0;
                        writeM     <= 1'b0;
                        last_grant <= gnt_port;
                        if (gnt_port == PORT_D) begin
                            d_done <= 1'b1;
                            if (!gnt_we) d_rdata <= data;
                        end else begin
                            i_done    <= 1'b1;
                            i_rdata   <= data;
                            num_fetch <= num_fetch + WORD_SIZE'(1);
                        end
                    end else begin
                        lat_cnt <= lat_cnt - CW'(1);
                    end
                end
                ST_RESP: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_bridge.sv
// Scoreboard bench for mem_bridge: drivers queue expected responses, a monitor
// pops and compares on each done pulse and checks the bus every cycle.
module tb_mem_bridge;

    localparam int LAT = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic        i_req;
    logic [15:0] i_addr;
    logic [15:0] i_rdata;
    logic        i_done;
    logic        d_req;
    logic        d_we;
    logic [15:0] d_addr;
    logic [15:0] d_wdata;
    logic [15:0] d_rdata;
    logic        d_done;
    logic        halt;
    logic        is_halted;
    logic        readM;
    logic        writeM;
    logic [15:0] address;
    wire  [15:0] data;
    logic [15:0] num_fetch;

    // Small second instance used only to see the fetch counter wrap
    logic        w_reset;
    logic        w_i_req;
    logic [7:0]  w_i_rdata;
    logic        w_i_done;
    logic [7:0]  w_d_rdata;
    logic        w_d_done;
    logic        w_is_halted;
    logic        w_readM;
    logic        w_writeM;
    logic [7:0]  w_address;
    wire  [7:0]  w_data;
    logic [7:0]  w_num_fetch;
    bit          w_finished = 1'b0;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic        we;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [15:0] rdata;
    } d_exp_t;

    logic [15:0] i_q[$];
    d_exp_t      d_q[$];
    bit          done_log[$];

    logic [15:0] bus_mem [0:1023];
    logic [15:0] ref_mem [0:1023];

    always #5 clk = ~clk;

    mem_bridge #(.WORD_SIZE(16), .MEM_LATENCY(LAT)) dut (
        .clk(clk), .reset(reset),
        .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_done(i_done),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_done(d_done),
        .halt(halt), .is_halted(is_halted),
        .readM(readM), .writeM(writeM), .address(address), .data(data),
        .num_fetch(num_fetch)
    );

    mem_bridge #(.WORD_SIZE(8), .MEM_LATENCY(1)) dut_w (
        .clk(clk), .reset(w_reset),
        .i_req(w_i_req), .i_addr(8'h33), .i_rdata(w_i_rdata), .i_done(w_i_done),
        .d_req(1'b0), .d_we(1'b0), .d_addr(8'h00), .d_wdata(8'h00),
        .d_rdata(w_d_rdata), .d_done(w_d_done),
        .halt(1'b0), .is_halted(w_is_halted),
        .readM(w_readM), .writeM(w_writeM), .address(w_address), .data(w_data),
        .num_fetch(w_num_fetch)
    );

    // Memory slaves: combinational read while readM, write on clock while writeM
    assign data   = readM   ? bus_mem[address[9:0]] : 'z;
    assign w_data = w_readM ? 8'hA5 : 'z;

    always @(posedge clk) begin
        if (!reset && writeM) bus_mem[address[9:0]] = data;
    end

    task automatic check(input bit ok, input string name,
                         input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Wait (bounded) for the done pulse of one port; returns cycles waited
    task automatic wait_done(input bit port, output int cycles, output bit ok);
        cycles = 0;
        ok = 1'b0;
        while (cycles < 200) begin
            @(negedge clk);
            cycles++;
            if ((port == 1'b1) ? d_done : i_done) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // ---------------- monitor ----------------
    int          run = 0;
    int          exp_fetch = 0;
    bit          prev_i = 1'b0;
    bit          prev_d = 1'b0;
    bit          bus_ok;
    logic [15:0] mon_e;
    d_exp_t      mon_d;

    always @(negedge clk) begin
        if (reset) begin
            run = 0;
            exp_fetch = 0;
            prev_i = 1'b0;
            prev_d = 1'b0;
        end else begin
            if (readM && writeM)  bus_ok = 1'b0;
            else if (writeM)      bus_ok = d_req && d_we && address == d_addr && data == d_wdata;
            else if (readM)       bus_ok = (i_req && address == i_addr) || (d_req && !d_we && address == d_addr);
            else                  bus_ok = $isunknown(data) || data == 16'h0000;
            if (!bus_ok) check(1'b0, "bus", {address, data}, {readM, writeM});
            else checks++;

            if (readM || writeM) run++;
            else if (run != 0) begin
                check(run == LAT && (i_done ^ d_done), "strobe_len", run, LAT);
                run = 0;
            end

            if (i_done) begin
                check(!prev_i && !d_done, "i_done_pulse", {prev_i, d_done}, 0);
                if (i_q.size() == 0) check(1'b0, "i_unexpected", i_rdata, 0);
                else begin
                    mon_e = i_q.pop_front();
                    check(i_rdata == mon_e, "i_rdata", i_rdata, mon_e);
                end
                exp_fetch++;
                check(num_fetch == 16'(exp_fetch), "num_fetch", num_fetch, 16'(exp_fetch));
                done_log.push_back(1'b0);
            end
            if (d_done) begin
                check(!prev_d, "d_done_pulse", prev_d, 0);
                if (d_q.size() == 0) check(1'b0, "d_unexpected", d_rdata, 0);
                else begin
                    mon_d = d_q.pop_front();
                    if (mon_d.we) check(bus_mem[mon_d.addr[9:0]] == mon_d.wdata, "d_write_mem",
                                        bus_mem[mon_d.addr[9:0]], mon_d.wdata);
                    else          check(d_rdata == mon_d.rdata, "d_rdata", d_rdata, mon_d.rdata);
                end
                done_log.push_back(1'b1);
            end
            prev_i = i_done;
            prev_d = d_done;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic issue_i(input logic [15:0] a);
        i_addr = a;
        i_q.push_back(ref_mem[a[9:0]]);
        i_req = 1'b1;
    endtask

    task automatic issue_d(input logic we, input logic [15:0] a, input logic [15:0] wd);
        d_exp_t e;
        e.we = we; e.addr = a; e.wdata = wd; e.rdata = ref_mem[a[9:0]];
        if (we) ref_mem[a[9:0]] = wd;
        d_q.push_back(e);
        d_we = we; d_addr = a; d_wdata = wd;
        d_req = 1'b1;
    endtask

    task automatic run_i(input int n);
        int c; bit ok;
        for (int k = 0; k < n; k++) begin
            issue_i(16'($urandom_range(0, 255)));
            wait_done(1'b0, c, ok);
            i_req = 1'b0;
            if (!ok) begin check(1'b0, "i_timeout", c, 0); break; end
            repeat ($urandom_range(0, 4)) @(negedge clk);
        end
    endtask

    task automatic run_d(input int n);
        int c; bit ok;
        for (int k = 0; k < n; k++) begin
            issue_d(1'($urandom_range(0, 1)), 16'(256 + $urandom_range(0, 255)),
                    16'($urandom) | 16'h0001);
            wait_done(1'b1, c, ok);
            d_req = 1'b0;
            if (!ok) begin check(1'b0, "d_timeout", c, 0); break; end
            repeat ($urandom_range(0, 4)) @(negedge clk);
        end
    endtask

    // ---------------- counter wrap on the 8-bit instance ----------------
    initial begin
        int cnt;
        int cyc;
        w_reset = 1'b1;
        w_i_req = 1'b0;
        repeat (3) @(negedge clk);
        w_reset = 1'b0;
        w_i_req = 1'b1;
        cnt = 0;
        cyc = 0;
        while (cnt < 257 && cyc < 2000) begin
            @(negedge clk);
            cyc++;
            if (w_i_done) begin
                cnt++;
                check(w_num_fetch == 8'(cnt) && w_i_rdata == 8'hA5, "wrap_count",
                      {w_i_rdata, w_num_fetch}, {8'hA5, 8'(cnt)});
            end
        end
        check(cnt == 257, "wrap_timeout", cnt, 257);
        w_i_req = 1'b0;
        w_finished = 1'b1;
    end

    // ---------------- main sequence ----------------
    initial begin
        int  c;
        bit  ok;
        for (int k = 0; k < 1024; k++) begin
            ref_mem[k] = 16'($urandom);
            bus_mem[k] = ref_mem[k];
        end
        reset = 1'b1; halt = 1'b1;
        i_req = 1'b0; i_addr = '0;
        d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
        repeat (2) @(negedge clk);
        check(!readM && !writeM && address == 16'h0 && !i_done && !d_done,
              "reset_bus", {readM, writeM, address}, 0);
        check(i_rdata == 16'h0 && d_rdata == 16'h0 && num_fetch == 16'h0,
              "reset_regs", {i_rdata, d_rdata}, 0);
        check($isunknown(data) || data == 16'h0, "reset_data_z", data, 0);
        check(is_halted == 1'b1, "reset_is_halted_1", is_halted, 1);
        halt = 1'b0;
        #1;
        check(is_halted == 1'b0, "reset_is_halted_0", is_halted, 0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // Both requests held: D, I, D, I, D, I
        done_log.delete();
        for (int k = 0; k < 3; k++) begin
            i_q.push_back(ref_mem[16'h040]);
            d_q.push_back('{we: 1'b0, addr: 16'h0140, wdata: 16'h0, rdata: ref_mem[16'h140]});
        end
        i_addr = 16'h0040; i_req = 1'b1;
        d_we = 1'b0; d_addr = 16'h0140; d_req = 1'b1;
        c = 0;
        while (done_log.size() < 6 && c < 300) begin @(negedge clk); c++; end
        i_req = 1'b0; d_req = 1'b0;
        check(done_log.size() == 6, "alt_count", done_log.size(), 6);
        for (int k = 0; k < done_log.size() && k < 6; k++)
            check(done_log[k] == ((k % 2) == 0), $sformatf("alt_order%0d", k), done_log[k], (k % 2) == 0);
        repeat (3) @(negedge clk);

        // Single fetch of a known word, with latency check
        ref_mem[16'h010] = 16'hBEEF; bus_mem[16'h010] = 16'hBEEF;
        issue_i(16'h0010);
        wait_done(1'b0, c, ok);
        i_req = 1'b0;
        check(ok && c == LAT + 1, "i_latency", c, LAT + 1);
        check(i_rdata == 16'hBEEF, "i_rdata_beef", i_rdata, 16'hBEEF);
        @(negedge clk);

        // Data write, then read it back through the fetch port
        issue_d(1'b1, 16'h0020, 16'h1234);
        wait_done(1'b1, c, ok);
        d_req = 1'b0;
        check(ok && c == LAT + 1, "d_latency", c, LAT + 1);
        check(bus_mem[16'h020] == 16'h1234, "mem_0x20", bus_mem[16'h020], 16'h1234);
        issue_i(16'h0020);
        wait_done(1'b0, c, ok);
        i_req = 1'b0;
        check(ok && i_rdata == 16'h1234, "readback_0x20", i_rdata, 16'h1234);
        @(negedge clk);

        // Halt raised in the first bus cycle of a fetch
        issue_i(16'h0055);
        c = 0;
        while (!readM && c < 20) begin @(negedge clk); c++; end
        check(readM == 1'b1, "halt_fetch_start", readM, 1);
        halt = 1'b1;
        issue_d(1'b0, 16'h0166, 16'h0);
        wait_done(1'b0, c, ok);
        i_req = 1'b0;
        check(ok && is_halted == 1'b0, "halt_resp_state", is_halted, 0);
        ok = 1'b1;
        repeat (8) begin
            @(negedge clk);
            if (!is_halted || readM || writeM || d_done) ok = 1'b0;
        end
        check(ok, "halt_blocks", {is_halted, readM, writeM, d_done}, 4'b1000);
        halt = 1'b0;
        wait_done(1'b1, c, ok);
        d_req = 1'b0;
        check(ok, "halt_resume", c, 0);
        @(negedge clk);

        // Randomised traffic on both ports
        fork
            run_i(40);
            run_d(40);
        join
        repeat (4) @(negedge clk);
        check(i_q.size() == 0 && d_q.size() == 0, "queues_drained", i_q.size() + d_q.size(), 0);

        // Reset in the middle of a write
        issue_d(1'b1, 16'h0150, 16'hA5A3);
        c = 0;
        while (!writeM && c < 20) begin @(negedge clk); c++; end
        @(negedge clk);
        check(writeM == 1'b1, "mid_write_active", writeM, 1);
        reset = 1'b1;
        #1;
        check(!readM && !writeM && ($isunknown(data) || data == 16'h0), "reset_abort",
              {readM, writeM, data}, 0);
        check(num_fetch == 16'h0 && i_rdata == 16'h0 && d_rdata == 16'h0, "reset_abort_regs",
              {num_fetch, d_rdata}, 0);
        d_req = 1'b0;
        d_q.delete();
        @(negedge clk);
        reset = 1'b0;
        ok = 1'b1;
        repeat (8) begin
            @(negedge clk);
            if (d_done || i_done || readM || writeM) ok = 1'b0;
        end
        check(ok, "no_done_after_abort", {d_done, i_done}, 0);

        c = 0;
        while (!w_finished && c < 3000) begin @(negedge clk); c++; end
        check(w_finished, "wrap_finished", w_finished, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
